data_mem_port: RTL and testbench
================================

Name: data_mem_port

Overview:
- Executes the memory access described by the load/store decoder's LoadType/StoreType codes.
- Converts a CPU-side request (byte address, store data, type codes) into a word-aligned, byte-enabled transaction on the data-memory bus, waiting for acknowledge.
- On loads, selects the addressed byte or halfword lane and zero-/sign-extends it to 32 bits.
- Sits between the datapath/controller and data memory; stalls the core through `busy` until `done`.

Parameters:
- ADDR_W, 32, byte-address width on both the CPU side and the memory side.
- TIMEOUT_CYCLES, 16, maximum number of WAIT cycles without `mem_ack` before a bus error; must be ≥1.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  one-cycle request strobe; sampled only in IDLE.
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data, right-justified.
- LoadType  in  3  0=LW, 1=LBU, 2=LB, 4=LHU, 5=LH, 7=none; 3 and 6 are treated as none.
- StoreType  in  2  0=SW, 1=SB, 2=SH, 3=none.
- busy  out  1  high from the cycle after acceptance until the cycle `done` is high, inclusive.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  extended load result; held until the next `done`.
- bus_err  out  1  valid with `done`: the access timed out.
- misaligned  out  1  valid with `done`: see Optional Feature.
- mem_req  out  1  memory request; held until ack or timeout.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  word address; bits [1:0] are always 0.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  read data, valid when `mem_ack` is high.
- mem_ack  in  1  one-cycle acknowledge.

Behaviour:
- Reset values: state=IDLE; busy, done, mem_req, mem_we, bus_err, misaligned = 0; mem_be=0; mem_addr, mem_wdata, rdata = 0.
- Operation selection:
  - A request is a store if StoreType≠3.
  - Otherwise it is a load if LoadType ∈ {0,1,2,4,5}.
  - Otherwise it is a null op.
  - Store has priority if both codes are active.
- Request capture: on acceptance, register addr, wdata and both type codes. Inputs may change afterwards without effect.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE→REQ: req_valid and not null.
  - IDLE→DONE: req_valid and null op. No bus cycle is issued; rdata is unchanged.
  - REQ: drive mem_req=1 plus address, enables and data for one cycle, then go to WAIT.
  - WAIT: hold all bus outputs. When mem_ack=1, capture the extended read data (loads only), clear mem_req on the next edge, and go to DONE.
  - WAIT timeout: a counter increments on each WAIT cycle without ack. When it reaches TIMEOUT_CYCLES, drop mem_req, set bus_err, force rdata=0 for loads, and go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- Back-to-back: a req_valid arriving in the DONE cycle is ignored; the controller re-issues it.
- An ack arriving in the REQ cycle is honoured: go directly to DONE.
- Minimum latency: acceptance edge → done = 3 cycles with an immediate ack.
- Byte enables and store data:
  - SW: be=1111, wdata unchanged.
  - SH: be=0011 or 1100 selected by addr[1]; mem_wdata={2{wdata[15:0]}}.
  - SB: be=0001<<addr[1:0]; mem_wdata={4{wdata[7:0]}}.
  - Loads: be=1111, mem_we=0.
- Load extension:
  - Byte lane = mem_rdata[8*addr[1:0] +: 8].
  - Half lane = mem_rdata[16*addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Reset mid-operation: state returns to IDLE and all outputs take their reset values on that edge. A later stray mem_ack in IDLE is ignored.

Optional Feature:
- Macro: DATA_MEM_MISALIGN_TRAP_EN.
- With the macro defined:
  - A halfword access with addr[0]=1, or a word access with addr[1:0]≠0, issues no bus cycle.
  - The FSM goes IDLE→DONE with misaligned=1; rdata is unchanged.
- Without the macro:
  - Low address bits that are illegal for the access size are ignored: halfword uses addr[1], word uses none.
  - misaligned is tied to 0.

Decomposition:
- Shared package/include `mem_access_pkg`:
  - LoadType codes LT_LW, LT_LBU, LT_LB, LT_LHU, LT_LH, LT_NONE.
  - StoreType codes ST_SW, ST_SB, ST_SH, ST_NONE.
  - FSM state encodings.
- The decoder and this block both import these codes.
- One combinational sub-module, `load_extend` (inputs: mem_rdata, addr[1:0], LoadType; output: extended result), reused by any future cache path.

Test Plan:
- SB: addr=0x1002, wdata=0x000000A5, immediate ack → mem_addr=0x1000, be=0100, mem_wdata=0xA5A5A5A5, mem_we=1, done 3 cycles after acceptance.
- LB/LBU: addr=0x2003, mem_rdata=0x80123456 → LB rdata=0xFFFFFF80; LBU rdata=0x00000080.
- LH: addr=0x2002, mem_rdata=0x9ABC1234 → rdata=0xFFFF9ABC. SH at addr=0x2002 with wdata=0x5678 → be=1100, mem_wdata=0x56785678.
- Timeout: LW with mem_ack held 0 and TIMEOUT_CYCLES=16 → mem_req falls after 16 WAIT cycles, done with bus_err=1, rdata=0.
- Null op: LoadType=7, StoreType=3 → mem_req never asserted, done 1 cycle after acceptance. Reset asserted in WAIT → mem_req=0, busy=0 next cycle; a later ack produces no done.
- With DATA_MEM_MISALIGN_TRAP_EN: LW at addr=0x1001 → no mem_req, done with misaligned=1. Without the macro: same request reads word 0x1000.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared load/store type codes, FSM state encoding and small decode helpers
// used by the load/store decoder and by data_mem_port.
package mem_access_pkg;

  // LoadType codes; 3 and 6 are unused and behave like LT_NONE.
  localparam logic [2:0] LT_LW   = 3'd0;
  localparam logic [2:0] LT_LBU  = 3'd1;
  localparam logic [2:0] LT_LB   = 3'd2;
  localparam logic [2:0] LT_LHU  = 3'd4;
  localparam logic [2:0] LT_LH   = 3'd5;
  localparam logic [2:0] LT_NONE = 3'd7;

  // StoreType codes.
  localparam logic [1:0] ST_SW   = 2'd0;
  localparam logic [1:0] ST_SB   = 2'd1;
  localparam logic [1:0] ST_SH   = 2'd2;
  localparam logic [1:0] ST_NONE = 2'd3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StDone = 2'd3
  } state_e;

  function automatic logic lt_is_load(input logic [2:0] lt);
    return (lt == LT_LW) || (lt == LT_LBU) || (lt == LT_LB) ||
           (lt == LT_LHU) || (lt == LT_LH);
  endfunction

  function automatic logic lt_is_half(input logic [2:0] lt);
    return (lt == LT_LHU) || (lt == LT_LH);
  endfunction

  // Byte enables for a store; anything that is not SB/SH (loads included) is a full word.
  function automatic logic [3:0] store_be(input logic [1:0] st, input logic [1:0] lo);
    logic [3:0] be;
    case (st)
      ST_SB:   be = 4'b0001 << lo;
      ST_SH:   be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the narrow store value across every lane so the enables pick the right one.
  function automatic logic [31:0] store_data(input logic [1:0] st, input logic [31:0] wd);
    logic [31:0] d;
    case (st)
      ST_SB:   d = {4{wd[7:0]}};
      ST_SH:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Lane select and zero/sign extension of a memory read word, driven by LoadType.
// Purely combinational so a cache path can reuse it.
module load_extend
  import mem_access_pkg::*;
(
  input  logic [31:0] mem_rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  load_type_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Pick the addressed byte and halfword lanes.
  always_comb begin
    byte_lane = mem_rdata_i[7:0];
    unique case (addr_lo_i)
      2'd0: byte_lane = mem_rdata_i[7:0];
      2'd1: byte_lane = mem_rdata_i[15:8];
      2'd2: byte_lane = mem_rdata_i[23:16];
      2'd3: byte_lane = mem_rdata_i[31:24];
      default: byte_lane = mem_rdata_i[7:0];
    endcase
    half_lane = addr_lo_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
  end

  // Extend the selected lane; LW and unused codes pass the word through.
  always_comb begin
    case (load_type_i)
      LT_LB:   result_o = {{24{byte_lane[7]}}, byte_lane};
      LT_LBU:  result_o = {24'h0, byte_lane};
      LT_LH:   result_o = {{16{half_lane[15]}}, half_lane};
      LT_LHU:  result_o = {16'h0, half_lane};
      default: result_o = mem_rdata_i;
    endcase
  end

endmodule

// File: rtl/data_mem_port.sv
// data_mem_port: turns a CPU load/store request into one word-aligned, byte-enabled
// bus transaction, waits for ack (or times out) and returns the extended load data.
// Optional build macro DATA_MEM_MISALIGN_TRAP_EN: trap misaligned half/word accesses
// without touching the bus and report them through `misaligned`.
module data_mem_port
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [2:0]        LoadType,
  input  logic [1:0]        StoreType,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              bus_err,
  output logic              misaligned,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  state_e            state_q;
  logic              busy_q, done_q, bus_err_q, misaligned_q;
  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0]        mem_be_q;
  logic [31:0]       mem_wdata_q, rdata_q;
  logic [1:0]        addr_lo_q;
  logic [2:0]        lt_q;
  logic              is_load_q;
  logic [CntW-1:0]   cnt_q;

  logic              op_store, op_load, op_null, op_misaligned;
  logic [3:0]        op_be;
  logic [31:0]       op_wdata;
  logic [31:0]       ext_rdata;

  // Classify the incoming request; a store wins over a simultaneous load code.
  always_comb begin
    op_store      = (StoreType != ST_NONE);
    op_load       = !op_store && lt_is_load(LoadType);
    op_null       = !op_store && !op_load;
    op_be         = op_load ? 4'b1111 : store_be(StoreType, addr[1:0]);
    op_wdata      = store_data(StoreType, wdata);
    op_misaligned = 1'b0;
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    if (op_store) begin
      op_misaligned = ((StoreType == ST_SH) && addr[0]) ||
                      ((StoreType == ST_SW) && (addr[1:0] != 2'b00));
    end else if (op_load) begin
      op_misaligned = (lt_is_half(LoadType) && addr[0]) ||
                      ((LoadType == LT_LW) && (addr[1:0] != 2'b00));
    end
`endif
  end

  load_extend u_load_extend (
    .mem_rdata_i (mem_rdata),
    .addr_lo_i   (addr_lo_q),
    .load_type_i (lt_q),
    .result_o    (ext_rdata)
  );

  // Request FSM with all outputs registered; done/bus_err/misaligned are single-cycle pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      bus_err_q    <= 1'b0;
      misaligned_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= 4'b0000;
      mem_wdata_q  <= 32'h0;
      rdata_q      <= 32'h0;
      addr_lo_q    <= 2'b00;
      lt_q         <= LT_NONE;
      is_load_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      done_q       <= 1'b0;
      bus_err_q    <= 1'b0;
      misaligned_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            busy_q    <= 1'b1;
            addr_lo_q <= addr[1:0];
            lt_q      <= LoadType;
            is_load_q <= op_load;
            cnt_q     <= '0;
            if (op_null || op_misaligned) begin
              // No bus cycle; rdata keeps its previous value.
              state_q      <= StDone;
              done_q       <= 1'b1;
              misaligned_q <= op_misaligned;
            end else begin
              state_q     <= StReq;
              mem_req_q   <= 1'b1;
              mem_we_q    <= op_store;
              mem_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
              mem_be_q    <= op_be;
              mem_wdata_q <= op_wdata;
            end
          end
        end
        StReq, StWait: begin
          if (mem_ack) begin
            // An ack already in the REQ cycle finishes the access just the same.
            state_q   <= StDone;
            done_q    <= 1'b1;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_be_q  <= 4'b0000;
            if (is_load_q) rdata_q <= ext_rdata;
          end else if ((state_q == StWait) && (cnt_q == CntMax)) begin
            state_q   <= StDone;
            done_q    <= 1'b1;
            bus_err_q <= 1'b1;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_be_q  <= 4'b0000;
            if (is_load_q) rdata_q <= 32'h0;
          end else begin
            state_q <= StWait;
            if (state_q == StWait) cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          // A request arriving now is dropped; the controller re-issues it.
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rdata      = rdata_q;
  assign bus_err    = bus_err_q;
  assign misaligned = misaligned_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_data_mem_port.sv
// Scoreboard bench for data_mem_port: the driver pushes expected bus beats and
// completions; independent monitors pop and compare when the DUT presents them.
module tb_data_mem_port;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] addr, wdata;
  logic [2:0]  LoadType;
  logic [1:0]  StoreType;
  logic        busy, done, bus_err, misaligned;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;

  always #5 clk = ~clk;

  data_mem_port #(
    .ADDR_W         (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .addr       (addr),
    .wdata      (wdata),
    .LoadType   (LoadType),
    .StoreType  (StoreType),
    .busy       (busy),
    .done       (done),
    .rdata      (rdata),
    .bus_err    (bus_err),
    .misaligned (misaligned),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        mis;
    int          lat;
    int          reqcnt;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } bus_t;

  resp_t rq[$];
  bus_t  bq[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int reqcnt = 0;
  int done_cnt = 0;
  int ack_mode = 1;  // 0 never, 1 one cycle after mem_req, 2 in the REQ cycle, 3 bench-driven
  logic rsp_prev = 1'b0;
  logic rsp_acked = 1'b0;
  logic bm_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Memory model: acknowledges each request once according to ack_mode.
  initial begin
    mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_mode != 3) begin
        mem_ack = 1'b0;
        if (!mem_req) rsp_acked = 1'b0;
        else if (!rsp_acked && ((ack_mode == 2) || (ack_mode == 1 && rsp_prev))) begin
          mem_ack   = 1'b1;
          rsp_acked = 1'b1;
        end
      end
      rsp_prev = mem_req;
    end
  end

  // Bus monitor: checks the beat presented on the first cycle of each request.
  initial begin
    bus_t e;
    forever begin
      @(negedge clk);
      if (mem_req && !bm_prev) begin
        if (bq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_bus_req: got addr %h want none", mem_addr);
        end else begin
          e = bq.pop_front();
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_be", {28'h0, mem_be}, {28'h0, e.be});
          chk("mem_we", {31'h0, mem_we}, {31'h0, e.we});
          if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
        end
      end
      bm_prev = mem_req;
    end
  end

  // Completion monitor: checks each done pulse against the scoreboard.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (mem_req) reqcnt++;
      if (done) begin
        done_cnt++;
        if (rq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 want 0");
        end else begin
          r = rq.pop_front();
          chk("rdata", rdata, r.rdata);
          chk("bus_err", {31'h0, bus_err}, {31'h0, r.err});
          chk("misaligned", {31'h0, misaligned}, {31'h0, r.mis});
          chk("latency", cyc - acc_cyc, r.lat);
          chk("mem_req_cycles", reqcnt, r.reqcnt);
          chk("busy_at_done", {31'h0, busy}, 32'h1);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] lt,
                       input logic [1:0] st, input int am, input logic [31:0] rd,
                       input logic bus_exp, input logic [31:0] eaddr, input logic [3:0] ebe,
                       input logic [31:0] ewd, input logic ewe, input logic [31:0] erd,
                       input logic eerr, input logic emis, input int elat, input int ecnt);
    bus_t  b;
    resp_t r;
    int    k;
    b.addr = eaddr; b.be = ebe; b.wdata = ewd; b.we = ewe;
    r.rdata = erd; r.err = eerr; r.mis = emis; r.lat = elat; r.reqcnt = ecnt;
    @(negedge clk);
    ack_mode  = am;
    mem_rdata = rd;
    addr      = a;
    wdata     = wd;
    LoadType  = lt;
    StoreType = st;
    req_valid = 1'b1;
    acc_cyc   = cyc;
    reqcnt    = 0;
    if (bus_exp) bq.push_back(b);
    rq.push_back(r);
    @(negedge clk);
    // Scramble the inputs: the DUT must use its captured copy.
    req_valid = 1'b0;
    addr      = ~a;
    wdata     = ~wd;
    LoadType  = LT_LB;
    StoreType = ST_NONE;
    k = 0;
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL wait_done: got no done want done within 60 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1);
  end

  initial begin
    int saved;
    reset = 1'b1; req_valid = 1'b0; addr = 32'h0; wdata = 32'h0;
    LoadType = LT_NONE; StoreType = ST_NONE; mem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
    chk("rst_misaligned", {31'h0, misaligned}, 32'h0);
    chk("rst_mem_be", {28'h0, mem_be}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    reset = 1'b0;

    //    addr          wdata         LT       ST       am rd_value    bus eaddr         be       ewdata        we    erdata        err   mis   lat cnt
    issue(32'h1002, 32'h000000A5, LT_NONE, ST_SB,   1, 32'h0,        1, 32'h1000, 4'b0100, 32'hA5A5A5A5, 1'b1, 32'h0,        1'b0, 1'b0, 3,  2);
    issue(32'h2003, 32'h0,        LT_LB,   ST_NONE, 1, 32'h80123456, 1, 32'h2000, 4'b1111, 32'h0,        1'b0, 32'hFFFFFF80, 1'b0, 1'b0, 3,  2);
    issue(32'h2003, 32'h0,        LT_LBU,  ST_NONE, 1, 32'h80123456, 1, 32'h2000, 4'b1111, 32'h0,        1'b0, 32'h00000080, 1'b0, 1'b0, 3,  2);
    issue(32'h2002, 32'h0,        LT_LH,   ST_NONE, 1, 32'h9ABC1234, 1, 32'h2000, 4'b1111, 32'h0,        1'b0, 32'hFFFF9ABC, 1'b0, 1'b0, 3,  2);
    issue(32'h2002, 32'h00005678, LT_NONE, ST_SH,   1, 32'h0,        1, 32'h2000, 4'b1100, 32'h56785678, 1'b1, 32'hFFFF9ABC, 1'b0, 1'b0, 3,  2);
    // Ack already in the REQ cycle.
    issue(32'h2000, 32'h0,        LT_LHU,  ST_NONE, 2, 32'h9ABC8001, 1, 32'h2000, 4'b1111, 32'h0,        1'b0, 32'h00008001, 1'b0, 1'b0, 2,  1);
    issue(32'h3004, 32'hDEADBEEF, LT_NONE, ST_SW,   1, 32'h0,        1, 32'h3004, 4'b1111, 32'hDEADBEEF, 1'b1, 32'h00008001, 1'b0, 1'b0, 3,  2);
    issue(32'h3008, 32'h0,        LT_LW,   ST_NONE, 1, 32'h12345678, 1, 32'h3008, 4'b1111, 32'h0,        1'b0, 32'h12345678, 1'b0, 1'b0, 3,  2);
    // Timeout: 1 REQ + 16 WAIT cycles of mem_req, then done with bus_err and rdata forced to 0.
    issue(32'h400C, 32'h0,        LT_LW,   ST_NONE, 0, 32'hFFFFFFFF, 1, 32'h400C, 4'b1111, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 18, 17);
    issue(32'h1234, 32'h0,        LT_NONE, ST_NONE, 1, 32'h0,        0, 32'h0,    4'b0000, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1,  0);
    issue(32'h1234, 32'h0,        3'd3,    ST_NONE, 1, 32'h0,        0, 32'h0,    4'b0000, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1,  0);
    // Store code wins over a simultaneous load code.
    issue(32'h5001, 32'h11223344, LT_LW,   ST_SB,   1, 32'h0,        1, 32'h5000, 4'b0010, 32'h44444444, 1'b1, 32'h0,        1'b0, 1'b0, 3,  2);
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    issue(32'h1001, 32'h0,        LT_LW,   ST_NONE, 1, 32'hCAFEF00D, 0, 32'h0,    4'b0000, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1,  0);
    issue(32'h5001, 32'h0,        LT_LB,   ST_NONE, 1, 32'h00007F00, 1, 32'h5000, 4'b1111, 32'h0,        1'b0, 32'h0000007F, 1'b0, 1'b0, 3,  2);
`else
    issue(32'h1001, 32'h0,        LT_LW,   ST_NONE, 1, 32'hCAFEF00D, 1, 32'h1000, 4'b1111, 32'h0,        1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 3,  2);
    issue(32'h5001, 32'h0,        LT_LB,   ST_NONE, 1, 32'h00007F00, 1, 32'h5000, 4'b1111, 32'h0,        1'b0, 32'h0000007F, 1'b0, 1'b0, 3,  2);
`endif

    // Reset while waiting for an ack, then a stray ack in IDLE.
    @(negedge clk);
    ack_mode  = 0;
    addr      = 32'h6000;
    LoadType  = LT_LW;
    StoreType = ST_NONE;
    req_valid = 1'b1;
    bq.push_back('{addr: 32'h6000, be: 4'b1111, wdata: 32'h0, we: 1'b0});
    @(negedge clk);
    req_valid = 1'b0;
    ack_mode  = 3;
    repeat (3) @(negedge clk);
    chk("wait_mem_req", {31'h0, mem_req}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_mem_be", {28'h0, mem_be}, 32'h0);
    chk("midrst_rdata", rdata, 32'h0);
    reset = 1'b0;
    saved = done_cnt;
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    repeat (4) @(negedge clk);
    chk("stray_ack_done_cnt", done_cnt, saved);
    chk("stray_ack_busy", {31'h0, busy}, 32'h0);
    chk("resp_queue_empty", rq.size(), 32'h0);
    chk("bus_queue_empty", bq.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
